// File: rtl/alu_issue_controller.sv
// alu_issue_controller
//   Issue stage in front of an 8-bit signed ALU. Accepts one 16-bit
//   instruction at a time over valid/ready, reads operands from a 4 x 8-bit
//   register file, drives the ALU for ALU_LATENCY cycles, then writes the
//   ALU result back and reports it. LI is executed locally.
//
//   Ports:
//     clock_in, reset_in (async, active-high), enable_in (global freeze)
//     instr_in[15:0], instr_valid_in, instr_ready_out   instruction handshake
//     alu_opcode_out, alu_input1_out, alu_input2_out,
//     alu_enable_out, alu_result_in                     ALU interface
//     result_out, result_reg_out, result_valid_out      writeback report
//     illegal_out                                       illegal-opcode pulse
//     reg_sel_in, reg_data_out                          debug register read
//
//   Instruction: [15:13] opcode, [12] imm_sel, [11:10] rd, [9:8] rs1,
//                [7:6] rs2 (imm_sel=0) or [7:0] imm8 (imm_sel=1).
module alu_issue_controller #(
  parameter int ALU_LATENCY = 1
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              enable_in,
  input  logic [15:0]       instr_in,
  input  logic              instr_valid_in,
  output logic              instr_ready_out,
  output logic [2:0]        alu_opcode_out,
  output logic signed [7:0] alu_input1_out,
  output logic signed [7:0] alu_input2_out,
  output logic              alu_enable_out,
  input  logic signed [7:0] alu_result_in,
  output logic signed [7:0] result_out,
  output logic [1:0]        result_reg_out,
  output logic              result_valid_out,
  output logic              illegal_out,
  input  logic [1:0]        reg_sel_in,
  output logic signed [7:0] reg_data_out
);

  localparam logic [2:0] LAT = 3'(ALU_LATENCY);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic [1:0]        rd_q;
  logic signed [7:0] regs [4];

  logic [2:0]        opcode;
  logic              imm_sel;
  logic [1:0]        rd;
  logic [1:0]        rs1;
  logic [1:0]        rs2;
  logic signed [7:0] imm8;
  logic              hs;
  logic              is_alu;
  logic              is_li;
  logic              is_ill;
  logic              exec_done;

  assign opcode  = instr_in[15:13];
  assign imm_sel = instr_in[12];
  assign rd      = instr_in[11:10];
  assign rs1     = instr_in[9:8];
  assign rs2     = instr_in[7:6];
  assign imm8    = instr_in[7:0];

  assign is_alu = (opcode <= 3'd4);
  assign is_li  = (opcode == 3'd5);
  assign is_ill = opcode[2] & opcode[1];

  assign instr_ready_out  = enable_in && (state == IDLE);
  assign hs               = instr_valid_in && instr_ready_out;
  // Last ALU cycle: the result is sampled on the edge that ends it.
  assign exec_done        = (state == EXEC) && (cnt == 3'd1);
  assign alu_enable_out   = (state == EXEC);
  assign result_valid_out = (state == WB);
  assign reg_data_out     = regs[reg_sel_in];

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enable_in) begin
      case (state)
        IDLE: begin
          if (hs && is_alu)     state_nxt = EXEC;
          else if (hs && is_li) state_nxt = WB;
        end
        EXEC: if (exec_done) state_nxt = WB;
        WB:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Issue / execute / writeback datapath
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      alu_opcode_out <= '0;
      alu_input1_out <= '0;
      alu_input2_out <= '0;
      result_out     <= '0;
      result_reg_out <= '0;
      illegal_out    <= 1'b0;
      rd_q           <= '0;
      cnt            <= '0;
    end else begin
      // hs already requires enable_in, so a frozen cycle never re-pulses.
      illegal_out <= hs && is_ill;
      if (enable_in) begin
        if (hs && is_alu) begin
          alu_opcode_out <= opcode;
          alu_input1_out <= regs[rs1];
          alu_input2_out <= imm_sel ? imm8 : regs[rs2];
          rd_q           <= rd;
          cnt            <= LAT;
        end
        if (hs && is_li) begin
          regs[rd]       <= imm8;
          result_out     <= imm8;
          result_reg_out <= rd;
        end
        if (state == EXEC) begin
          cnt <= cnt - 3'd1;
          if (exec_done) begin
            regs[rd_q]     <= alu_result_in;
            result_out     <= alu_result_in;
            result_reg_out <= rd_q;
          end
        end
      end
    end
  end

endmodule
